mem_arbiter_ram: RTL and testbench

//  Parametrised multi-requester front end to on-chip single-port byte-enabled RAM; the RAM is inferred internally.

---
 rtl/mem_arbiter_ram.sv | 102 ++++++++++
 tb/tb_mem_arbiter_ram.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ram.sv
// Round-robin front end arbitrating NUM_PORTS valid/ready requesters onto one inferred byte-enabled RAM port.
// One response per accept, exactly one cycle later; misaligned or out-of-range accesses answer with rsp_err.
module mem_arbiter_ram #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 16384
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0]  req_byte_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]      req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]      req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_W-1:0]                rsp_rdata,
  output logic                             rsp_err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);

  logic [PTR_W-1:0]     rr_q;
  logic [PTR_W-1:0]     sel;
  logic                 found;
  logic                 accept;
  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    word_idx;
  logic [IDX_W-1:0]     ram_idx;
  logic                 we;
  logic [BE_W-1:0]      be;
  logic [DATA_W-1:0]    wdata;
  logic                 err;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic                 rsp_err_q;
  logic                 rd_ok_q;
  logic [DATA_W-1:0]    ram_rd_q;
  logic [DATA_W-1:0]    mem [DEPTH];

  // First valid port found searching upward from the round-robin pointer.
  always_comb begin
    int p;
    p     = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = (int'(rr_q) + i) % NUM_PORTS;
      if (!found && req_valid[p]) begin
        found = 1'b1;
        sel   = PTR_W'(p);
      end
    end
  end

  assign accept    = found & rst_n;
  assign req_ready = accept ? (NUM_PORTS'(1) << sel) : '0;

  assign addr     = req_addr[sel*ADDR_W +: ADDR_W];
  assign we       = req_we[sel];
  assign be       = req_byte_en[sel*BE_W +: BE_W];
  assign wdata    = req_wdata[sel*DATA_W +: DATA_W];
  assign word_idx = addr >> OFF_W;
  assign ram_idx  = word_idx[IDX_W-1:0];
  assign err      = (|(addr & OFF_MASK)) | ({1'b0, word_idx} >= DEPTH_X);

  // RAM is deliberately outside reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && !err) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[ram_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        ram_rd_q <= mem[ram_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      rsp_valid_q <= req_ready;
      rsp_err_q   <= accept & err;
      rd_ok_q     <= accept & ~err & ~we;
      if (accept) rr_q <= (sel == PTR_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    end
  end

  // rst_n gating kills a response already registered when reset lands in its cycle.
  assign rsp_valid = rsp_valid_q & {NUM_PORTS{rst_n}};
  assign rsp_err   = rsp_err_q & rst_n;
  assign rsp_rdata = (rd_ok_q && rst_n) ? ram_rd_q : '0;
endmodule

// File: tb/tb_mem_arbiter_ram.sv
// Directed and randomized checks of mem_arbiter_ram against a word-array reference model.
module tb_mem_arbiter_ram;
  localparam int NP    = 2;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_we;
  logic [NP*4-1:0]   req_byte_en;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  mem_arbiter_ram #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte_en(req_byte_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [3:0] be,
                         input logic [AW-1:0] a, input logic [31:0] wd);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_byte_en[p*4 +: 4] = be;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*32 +: 32] = wd;
  endtask

  // One clock: predict the grant and the next-cycle response from the model, then compare.
  task automatic do_cycle(input string tag, output int acc);
    logic [NP-1:0] exp_rdy, exp_vld;
    logic          exp_err;
    logic [31:0]   exp_rd, wd;
    logic [AW-1:0] a;
    logic [3:0]    be;
    int            idx;
    #1;
    acc = -1;
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        if (acc < 0 && req_valid[(rr_m + i) % NP]) acc = (rr_m + i) % NP;
      end
    end
    exp_rdy = '0; exp_vld = '0; exp_err = 1'b0; exp_rd = '0;
    if (acc >= 0) begin
      exp_rdy[acc] = 1'b1;
      exp_vld[acc] = 1'b1;
      a   = req_addr[acc*AW +: AW];
      be  = req_byte_en[acc*4 +: 4];
      wd  = req_wdata[acc*32 +: 32];
      idx = int'(a) / 4;
      exp_err = (int'(a) % 4 != 0) || (idx >= DEPTH);
      if (!exp_err) begin
        if (req_we[acc]) begin
          for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          exp_rd = mem_m[idx];
        end
      end
      rr_m = (acc + 1) % NP;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) rr_m = 0;
    @(negedge clk);
    if (!rst_n) begin exp_vld = '0; exp_err = 1'b0; exp_rd = '0; end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_vld));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
  endtask

  task automatic single(input string tag, input int p, input logic we, input logic [3:0] be,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    int acc;
    set_req(p, 1'b1, we, be, a, wd);
    do_cycle(tag, acc);
    req_valid[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int acc;
    logic [AW-1:0] a;
    rst_n = 1'b0; req_valid = '1; req_we = '0; req_byte_en = '1; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    req_valid = '0;
    rst_n = 1'b1;
    rr_m = 0;

    for (int w = 0; w < DEPTH; w++) single("fill", 0, 1'b1, 4'hF, AW'(w * 4), $urandom);

    single("t1_wr", 0, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
    single("t1_rd", 0, 1'b0, 4'h0, 12'h010, 32'h0);
    chk("t1_rd_const", rsp_rdata, 32'hDEADBEEF);

    single("t2_wr_full", 1, 1'b1, 4'hF, 12'h020, 32'h11223344);
    single("t2_wr_part", 0, 1'b1, 4'b0101, 12'h020, 32'hAABBCCDD);
    single("t2_wr_none", 1, 1'b1, 4'b0000, 12'h020, 32'h55555555);
    single("t2_rd", 1, 1'b0, 4'hF, 12'h020, 32'h0);
    chk("t2_rd_const", rsp_rdata, 32'h11BB33DD);

    set_req(0, 1'b1, 1'b0, 4'hF, AW'($urandom_range(0, DEPTH - 1) * 4), 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, AW'($urandom_range(0, DEPTH - 1) * 4), 32'h0);
    for (int c = 0; c < 8; c++) begin
      do_cycle("t3_rr", acc);
      if (acc >= 0) set_req(acc, 1'b1, 1'($urandom), 4'($urandom),
                            AW'($urandom_range(0, DEPTH - 1) * 4), $urandom);
    end
    req_valid = '0;

    single("t4_misalign", 0, 1'b0, 4'hF, 12'h003, 32'h0);
    chk("t4_misalign_err", 32'(rsp_err), 32'h1);
    single("t4_range", 1, 1'b0, 4'hF, AW'(DEPTH * 4), 32'h0);
    chk("t4_range_err", 32'(rsp_err), 32'h1);
    single("t4_wr_range", 0, 1'b1, 4'hF, AW'(DEPTH * 4 + 4), 32'h01234567);
    single("t4_wr_mis", 1, 1'b1, 4'hF, 12'h012, 32'h76543210);
    single("t4_chk_alias", 0, 1'b0, 4'hF, 12'h004, 32'h0);
    single("t4_chk_mis", 0, 1'b0, 4'hF, 12'h010, 32'h0);
    chk("t4_unchanged", rsp_rdata, 32'hDEADBEEF);

    single("t5_wr", 1, 1'b1, 4'hF, 12'h030, 32'hCAFEF00D);
    single("t5_rd", 0, 1'b0, 4'hF, 12'h030, 32'h0);
    chk("t5_rd_const", rsp_rdata, 32'hCAFEF00D);

    set_req(0, 1'b1, 1'b0, 4'hF, 12'h020, 32'h0);
    #1;
    chk("t6_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("t6_suppress_valid", 32'(rsp_valid), 32'h0);
    chk("t6_suppress_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    single("t6_rd_a", 0, 1'b0, 4'hF, 12'h020, 32'h0);
    chk("t6_keep_a", rsp_rdata, 32'h11BB33DD);
    single("t6_rd_b", 1, 1'b0, 4'hF, 12'h030, 32'h0);
    chk("t6_keep_b", rsp_rdata, 32'hCAFEF00D);

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] && $urandom_range(0, 9) < 7) begin
          a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1) * 4);
          set_req(p, 1'b1, 1'($urandom), 4'($urandom), a, $urandom);
        end
      end
      do_cycle("rand", acc);
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
    req_valid = '0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
